// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction memory loader. Consumes a
//               length-prefixed little-endian byte stream over valid/ready,
//               assembles 32-bit words, writes them one per WR cycle and
//               holds the core in reset until the image is complete.
//               Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6,
    S_CHK  = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;
`endif

  localparam logic [15:0] c_depth = 16'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic          w_accept;
  logic [15:0]   w_count;
  logic          w_count_bad;
  logic          w_last;

  // A byte moves only when the source offers it and the loader wants one.
  assign w_accept    = rx_valid && rx_ready;
  assign w_count     = {rx_data, len_lo_q};
  assign w_count_bad = (w_count == 16'd0) || (w_count > c_depth);
  assign w_last      = (16'(idx_q) == (len_q - 16'd1));

  // State and datapath registers; reset restores the idle, core-held state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_lo_q <= 8'd0;
      len_q    <= 16'd0;
      idx_q    <= '0;
      bcnt_q   <= 2'd0;
      word_q   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      chk_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  // Next-state and datapath updates; start is only honoured when not busy.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (w_accept) begin
          len_lo_d = rx_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (w_accept) begin
          len_d = w_count;
          if (w_count_bad) begin
            state_d = S_ERR;
          end else begin
            idx_d   = '0;
            bcnt_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_d   = 8'd0;
`endif
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          // First byte ends up in bits 7:0 after four right shifts.
          word_d = {rx_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) state_d = S_WR;
        end
      end
      S_WR: begin
        idx_d = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_d = w_last ? S_CHK : S_DATA;
`else
        state_d = w_last ? S_DONE : S_DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state, so rx_valid never reaches them.
  always_comb begin
    rx_ready = 1'b0;
    we       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      S_LEN0, S_LEN1, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_WR: begin
        we   = 1'b1;
        busy = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
      end
    endcase
  end

  assign waddr = idx_q;
  assign wdata = word_q;

endmodule
`default_nettype wire
